mem_bist: RTL and testbench

Parametrised memory fill/check engine for the CHIP-8 SoC. It is the hardware successor to the clear-memory and compare-region steps done by hand in simulation. On command it fills an address window with a constant or incrementing pattern, or reads the window back and compares it. It reports the first mismatch, and optionally the total number of mismatches. It sits beside the CPU on the shared synchronous-read memory port and owns that port only while `busy` is high.

---
 rtl/mem_bist_pkg.sv | 32 +++
 rtl/mem_bist_if.sv | 31 +++
 rtl/mem_bist_addr_gen.sv | 53 +++++
 rtl/mem_bist.sv | 190 +++++++++++++++++++
 tb/tb_mem_bist.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared types for the memory fill/check engine.
//   op_e    - command encodings on the op port
//   state_e - engine FSM states
//   op_is_check / op_is_inc - op decode helpers
package mem_bist_pkg;

  localparam int unsigned OP_WIDTH = 2;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_FILL      = 2'b00,
    OP_CHECK     = 2'b01,
    OP_FILL_INC  = 2'b10,
    OP_CHECK_INC = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic logic op_is_check(input logic [OP_WIDTH-1:0] op);
    return (op == OP_CHECK) || (op == OP_CHECK_INC);
  endfunction

  function automatic logic op_is_inc(input logic [OP_WIDTH-1:0] op);
    return (op == OP_FILL_INC) || (op == OP_CHECK_INC);
  endfunction

endpackage

// File: rtl/mem_bist_if.sv
// mem_bist_if: synchronous-read memory port shared with the CPU.
//   mem_addr  - word address
//   mem_we    - write enable
//   mem_wdata - write data
//   mem_rdata - read data, valid one cycle after mem_addr
// Modports: master (engine side), slave (memory side).
interface mem_bist_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_bist_addr_gen.sv
// mem_bist_addr_gen: window walker for mem_bist.
//   clk, reset    - clock, synchronous active-high reset
//   load          - latch base/len/pattern/op for a new window
//   step          - advance to the next word
//   base, len     - window start and word count
//   pattern, op   - data seed and op (op selects incrementing data)
//   addr, data    - registered address and data/expected value of current word
//   last_c        - current word is the final word of the window
module mem_bist_addr_gen
  import mem_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic [OP_WIDTH-1:0]   op,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last_c
);

  logic [CNT_WIDTH-1:0] remaining;
  logic                 inc;

  // Address and data wrap naturally at their widths.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      data      <= '0;
      remaining <= '0;
      inc       <= 1'b0;
    end else if (load) begin
      addr      <= base;
      data      <= pattern;
      remaining <= len;
      inc       <= op_is_inc(op);
    end else if (step) begin
      addr      <= addr + ADDR_WIDTH'(1);
      data      <= data + DATA_WIDTH'(inc);
      remaining <= remaining - CNT_WIDTH'(1);
    end
  end

  assign last_c = (remaining == CNT_WIDTH'(1));

endmodule

// File: rtl/mem_bist.sv
// mem_bist: memory fill/check engine on the shared memory port.
//   clk, reset           - clock, synchronous active-high reset
//   start, op            - command strobe (IDLE only) and operation
//   base, len, pattern   - window start, word count, fill/expected seed
//   bus                  - memory port (mem_bist_if.master)
//   busy, done           - port ownership, one-cycle completion pulse
//   fail, fail_addr/data - sticky first-mismatch report
//   err_count            - mismatch count
// Build option MEM_BIST_ERRCNT_EN: when defined, CHECK scans the whole
// window and err_count counts every mismatch (saturating); otherwise CHECK
// stops at the first mismatch and err_count reads 0 or 1.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic [DATA_WIDTH-1:0] pattern,
  mem_bist_if.master            bus,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [CNT_WIDTH-1:0]  err_count
);

  state_e                state, state_d;
  logic                  busy_d, done_d, we_d, mem_we_q;
  logic                  gen_load, gen_step, gen_last;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic [DATA_WIDTH-1:0] gen_data;
  logic                  cmp_valid, cmp_valid_d;
  logic [DATA_WIDTH-1:0] cmp_exp;
  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic                  accept, mismatch, abort;

  mem_bist_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .load   (gen_load),
    .step   (gen_step),
    .base   (base),
    .len    (len),
    .pattern(pattern),
    .op     (op),
    .addr   (gen_addr),
    .data   (gen_data),
    .last_c (gen_last)
  );

  assign accept   = (state == ST_IDLE) && start;
  // Read data for the address issued last cycle is compared against its expected value.
  assign mismatch = cmp_valid && (bus.mem_rdata != cmp_exp);

`ifdef MEM_BIST_ERRCNT_EN
  logic [CNT_WIDTH-1:0] err_q;

  assign abort = 1'b0;

  // Saturating mismatch counter.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      err_q <= '0;
    end else if (mismatch && (err_q != '1)) begin
      err_q <= err_q + CNT_WIDTH'(1);
    end
  end

  assign err_count = err_q;
`else
  assign abort     = mismatch;
  assign err_count = CNT_WIDTH'(fail);
`endif

  // Next-state and next registered outputs.
  always_comb begin
    state_d     = state;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    we_d        = 1'b0;
    cmp_valid_d = 1'b0;
    gen_load    = 1'b0;
    gen_step    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (len == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            gen_load = 1'b1;
            if (op_is_check(op)) begin
              state_d = ST_READ;
            end else begin
              state_d = ST_WRITE;
              we_d    = 1'b1;
            end
          end
        end
      end
      ST_WRITE: begin
        busy_d = 1'b1;
        if (gen_last) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          gen_step = 1'b1;
          we_d     = 1'b1;
        end
      end
      ST_READ: begin
        busy_d = 1'b1;
        if (abort) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          cmp_valid_d = 1'b1;
          if (gen_last) begin
            state_d = ST_DRAIN;
          end else begin
            gen_step = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        busy_d  = 1'b1;
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, handshake outputs and compare pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_we_q  <= 1'b0;
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
      cmp_addr  <= '0;
    end else begin
      state     <= state_d;
      busy      <= busy_d;
      done      <= done_d;
      mem_we_q  <= we_d;
      cmp_valid <= cmp_valid_d;
      cmp_exp   <= gen_data;
      cmp_addr  <= gen_addr;
    end
  end

  // First-mismatch capture, cleared by an accepted command.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (mismatch && !fail) begin
      fail      <= 1'b1;
      fail_addr <= cmp_addr;
      fail_data <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr  = gen_addr;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = gen_data;

endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: self-checking bench for mem_bist with a behavioural memory
// and a window-level reference model of fill/check results and timing.
module tb_mem_bist;
  import mem_bist_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 13;
  localparam int unsigned MEM_WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [1:0]    op;
  logic [AW-1:0] base;
  logic [CW-1:0] len;
  logic [DW-1:0] pattern;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [CW-1:0] err_count;

  bit   [DW-1:0] mem     [MEM_WORDS];
  bit   [DW-1:0] ref_mem [MEM_WORDS];
  logic          poke_we;
  logic [AW-1:0] poke_addr;
  logic [DW-1:0] poke_data;
  logic [DW-1:0] rd;

  int n_tests = 0;
  int n_fail  = 0;

  // Results of the last run_op.
  int r_done_cyc, r_n_done, r_writes, r_busy_cyc;
  // Reference-model expectations.
  int e_done, e_writes, e_fail, e_faddr, e_fdata, e_err;

  mem_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .base     (base),
    .len      (len),
    .pattern  (pattern),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .fail     (fail),
    .fail_addr(fail_addr),
    .fail_data(fail_data),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; bench preloads through the poke port while the engine is idle.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (poke_we) mem[poke_addr] <= poke_data;
    rd <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = rd;

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < int'(MEM_WORDS); i++) if (mem[i] != ref_mem[i]) n++;
    return n;
  endfunction

  task automatic poke(input int a, input int d);
    @(negedge clk);
    poke_we = 1'b1; poke_addr = AW'(a); poke_data = DW'(d);
    @(posedge clk);
    #1 poke_we = 1'b0;
    ref_mem[a] = DW'(d);
  endtask

  // Window-level model: word k lives at (b+k) mod 2^AW and carries p (+k for _INC).
  task automatic model_op(input int o, input int b, input int n, input int p);
    int first, cnt, a, d;
    bit inc, chk;
    first = -1; cnt = 0;
    inc = (o == int'(OP_FILL_INC)) || (o == int'(OP_CHECK_INC));
    chk = (o == int'(OP_CHECK)) || (o == int'(OP_CHECK_INC));
    e_fail = 0; e_faddr = 0; e_fdata = 0; e_err = 0;
    for (int k = 0; k < n; k++) begin
      a = (b + k) % int'(MEM_WORDS);
      d = (p + (inc ? k : 0)) % 256;
      if (!chk) ref_mem[a] = DW'(d);
      else if (int'(ref_mem[a]) != d) begin
        if (first < 0) begin first = k; e_faddr = a; e_fdata = int'(ref_mem[a]); end
        cnt++;
      end
    end
    e_writes = chk ? 0 : n;
    e_fail   = (first >= 0) ? 1 : 0;
    if (n == 0) e_done = 1;
    else if (!chk) e_done = n + 1;
    else begin
`ifdef MEM_BIST_ERRCNT_EN
      e_done = n + 2;
      e_err  = cnt;
`else
      e_done = (first >= 0) ? first + 3 : n + 2;
      e_err  = e_fail;
`endif
    end
  endtask

  // Issue one command and observe it; cycle k is the k-th period after the accepting edge.
  task automatic run_op(input int o, input int b, input int n, input int p,
                        input int extra1, input int extra2);
    int limit;
    @(negedge clk);
    op = 2'(o); base = AW'(b); len = CW'(n); pattern = DW'(p); start = 1'b1;
    @(posedge clk);
    r_done_cyc = -1; r_n_done = 0; r_writes = 0; r_busy_cyc = 0;
    limit = n + 12;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      start = (cyc == extra1) || (cyc == extra2);
      if (cyc == 1) begin
        op = 2'($urandom); base = AW'($urandom); len = CW'($urandom); pattern = DW'($urandom);
      end
      if (done === 1'b1) begin r_n_done++; if (r_done_cyc < 0) r_done_cyc = cyc; end
      if (busy === 1'b1) r_busy_cyc++;
      if (bus.mem_we === 1'b1) r_writes++;
      if (r_done_cyc >= 0 && cyc >= r_done_cyc + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; poke_we = 1'b0;
    op = '0; base = '0; len = '0; pattern = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, done, fail, bus.mem_we} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got=%b want=0000", {busy, done, fail, bus.mem_we});
    end
    n_tests++;
    if ({bus.mem_addr, bus.mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_bus got addr=%h wdata=%h want 0", bus.mem_addr, bus.mem_wdata);
    end
    n_tests++;
    if ({fail_addr, fail_data, err_count} !== '0) begin
      n_fail++; $display("FAIL reset_result got fa=%h fd=%h ec=%0d want 0", fail_addr, fail_data, err_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_fill();
    model_op(int'(OP_FILL), 'h100, 'h100, 'h00);
    run_op(int'(OP_FILL), 'h100, 'h100, 'h00, -1, -1);
    n_tests++;
    if (r_done_cyc != e_done || r_done_cyc != 257) begin
      n_fail++; $display("FAIL fill_done_cycle got=%0d want=257", r_done_cyc);
    end
    n_tests++;
    if (r_writes != e_writes || r_busy_cyc != e_done || r_n_done != 1) begin
      n_fail++; $display("FAIL fill_counts got writes=%0d busy=%0d dones=%0d want %0d/%0d/1",
                         r_writes, r_busy_cyc, r_n_done, e_writes, e_done);
    end
    n_tests++;
    if (fail !== 1'b0) begin n_fail++; $display("FAIL fill_flag got=%b want=0", fail); end
    n_tests++;
    if (mem_diff() != 0) begin n_fail++; $display("FAIL fill_mem got %0d wrong words want 0", mem_diff()); end
  endtask

  task automatic test_fill_inc_wrap();
    logic [DW-1:0] w;
    model_op(int'(OP_FILL_INC), 'hFFE, 4, 'h40);
    run_op(int'(OP_FILL_INC), 'hFFE, 4, 'h40, -1, -1);
    n_tests++;
    if (r_done_cyc != e_done || r_writes != 4) begin
      n_fail++; $display("FAIL inc_wrap_timing got done=%0d writes=%0d want %0d/4", r_done_cyc, r_writes, e_done);
    end
    w = mem[0];
    n_tests++;
    if (w !== 8'h42 || mem[12'hFFF] !== 8'h41) begin
      n_fail++; $display("FAIL inc_wrap_words got [000]=%h [FFF]=%h want 42/41", w, mem[12'hFFF]);
    end
    n_tests++;
    if (mem_diff() != 0) begin n_fail++; $display("FAIL inc_wrap_mem got %0d wrong words want 0", mem_diff()); end
  endtask

  task automatic test_check_fail();
    for (int k = 0; k < 16; k++) poke('h020 + k, (k == 5) ? 'h13 : 'h42);
    model_op(int'(OP_CHECK), 'h020, 16, 'h42);
    run_op(int'(OP_CHECK), 'h020, 16, 'h42, -1, -1);
    n_tests++;
    if (fail !== 1'b1 || fail_addr !== 12'h025 || fail_data !== 8'h13) begin
      n_fail++; $display("FAIL check_capture got f=%b fa=%h fd=%h want 1/025/13", fail, fail_addr, fail_data);
    end
    n_tests++;
    if (r_done_cyc != e_done) begin
      n_fail++; $display("FAIL check_done_cycle got=%0d want=%0d", r_done_cyc, e_done);
    end
    n_tests++;
    if (err_count !== CW'(e_err) || r_writes != 0) begin
      n_fail++; $display("FAIL check_errcnt got ec=%0d writes=%0d want %0d/0", err_count, r_writes, e_err);
    end
  endtask

  task automatic test_check_len0();
    logic [AW-1:0] a0;
    a0 = bus.mem_addr;
    run_op(int'(OP_CHECK), 'h3C0, 0, 'h55, -1, -1);
    n_tests++;
    if (r_done_cyc != 1 || r_busy_cyc != 1) begin
      n_fail++; $display("FAIL len0_timing got done=%0d busy=%0d want 1/1", r_done_cyc, r_busy_cyc);
    end
    n_tests++;
    if (bus.mem_addr !== a0) begin n_fail++; $display("FAIL len0_addr got=%h want=%h", bus.mem_addr, a0); end
    n_tests++;
    if (fail !== 1'b0 || err_count !== '0) begin
      n_fail++; $display("FAIL len0_clear got f=%b ec=%0d want 0/0", fail, err_count);
    end
  endtask

  task automatic test_reset_mid();
    int writes;
    writes = 0;
    model_op(int'(OP_FILL), 'h400, 4, 'hA5);
    @(negedge clk);
    op = 2'(OP_FILL); base = 12'h400; len = CW'(64); pattern = 8'hA5; start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.mem_we === 1'b1) writes++;
      if (cyc == 4) reset = 1'b1;
      if (cyc == 5) begin
        n_tests++;
        if ({busy, done, fail, bus.mem_we, bus.mem_addr, bus.mem_wdata, fail_addr, fail_data, err_count} !== '0) begin
          n_fail++; $display("FAIL midreset_outputs got busy=%b we=%b addr=%h wdata=%h want all 0",
                             busy, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        reset = 1'b0;
      end
      if (cyc == 6) begin
        n_tests++;
        if (bus.mem_we !== 1'b0 || busy !== 1'b0) begin
          n_fail++; $display("FAIL midreset_idle got we=%b busy=%b want 0/0", bus.mem_we, busy);
        end
      end
    end
    n_tests++;
    if (writes != 4 || mem_diff() != 0) begin
      n_fail++; $display("FAIL midreset_mem got writes=%0d bad=%0d want 4/0", writes, mem_diff());
    end
  endtask

  task automatic test_back_to_back();
    model_op(int'(OP_FILL), 'h800, 8, 'h3C);
    run_op(int'(OP_FILL), 'h800, 8, 'h3C, 3, 9);
    n_tests++;
    if (r_writes != 8 || r_n_done != 1 || r_done_cyc != 9) begin
      n_fail++; $display("FAIL ignored_start got writes=%0d dones=%0d done=%0d want 8/1/9",
                         r_writes, r_n_done, r_done_cyc);
    end
    n_tests++;
    if (busy !== 1'b0 || mem_diff() != 0) begin
      n_fail++; $display("FAIL ignored_start_after got busy=%b bad=%0d want 0/0", busy, mem_diff());
    end
  endtask

  task automatic test_random();
    int o, b, n, p, sel, d;
    bit inc, chk;
    for (int it = 0; it < 30; it++) begin
      o = int'($urandom_range(0, 3));
      b = int'($urandom_range(0, MEM_WORDS - 1));
      p = int'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 7));
      n = (sel == 0) ? 0 : (sel == 1) ? 1 : int'($urandom_range(2, 40));
      inc = (o == int'(OP_FILL_INC)) || (o == int'(OP_CHECK_INC));
      chk = (o == int'(OP_CHECK)) || (o == int'(OP_CHECK_INC));
      if (chk) begin
        for (int k = 0; k < n; k++) begin
          d = (p + (inc ? k : 0)) % 256;
          if ($urandom_range(0, 5) == 0) d = int'($urandom_range(0, 255));
          poke((b + k) % int'(MEM_WORDS), d);
        end
      end
      model_op(o, b, n, p);
      run_op(o, b, n, p, -1, -1);
      n_tests++;
      if (r_done_cyc != e_done || r_n_done != 1 || r_busy_cyc != e_done || r_writes != e_writes) begin
        n_fail++; $display("FAIL rand%0d_timing op=%0d len=%0d got done=%0d dones=%0d busy=%0d wr=%0d want %0d/1/%0d/%0d",
                           it, o, n, r_done_cyc, r_n_done, r_busy_cyc, r_writes, e_done, e_done, e_writes);
      end
      n_tests++;
      if (fail !== 1'(e_fail) || fail_addr !== AW'(e_faddr) || fail_data !== DW'(e_fdata)) begin
        n_fail++; $display("FAIL rand%0d_capture got f=%b fa=%h fd=%h want %0d/%h/%h",
                           it, fail, fail_addr, fail_data, e_fail, e_faddr, e_fdata);
      end
      n_tests++;
      if (err_count !== CW'(e_err)) begin
        n_fail++; $display("FAIL rand%0d_errcnt got=%0d want=%0d", it, err_count, e_err);
      end
      n_tests++;
      if (mem_diff() != 0) begin n_fail++; $display("FAIL rand%0d_mem got %0d wrong words want 0", it, mem_diff()); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_fill_inc_wrap();
    test_check_fail();
    test_check_len0();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
